// File: rtl/matmul_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply sequencer.
package matmul_pkg;
  localparam int MM_N  = 10;  // matrix dimension / MAC lanes
  localparam int MM_DW = 16;  // signed operand width
  localparam int MM_RW = 32;  // signed result width
  localparam int MM_IW = 4;   // row/column index width
  localparam int MM_AW = 7;   // flat element address width

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/matmul_opmem.sv
// Operand storage: two NxN arrays with one write port and combinational
// row-of-A / column-of-B read muxes. Storage is deliberately not reset.
module matmul_opmem import matmul_pkg::*; #(
  parameter int N  = MM_N,
  parameter int DW = MM_DW,
  parameter int IW = MM_IW,
  parameter int AW = MM_AW
) (
  input  logic            clk,
  input  logic            we,
  input  logic            sel,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [IW-1:0]   ri,
  input  logic [IW-1:0]   cj,
  output logic [N*DW-1:0] row_a,
  output logic [N*DW-1:0] col_b
);
  logic [DW-1:0] mem_a [N][N];
  logic [DW-1:0] mem_b [N][N];
  logic          wr_ok;
  logic [IW-1:0] wr, wc;

  // Out-of-range addresses are accepted upstream but never land here
  assign wr_ok = we && (int'(addr) < N*N);
  assign wr    = IW'(int'(addr) / N);
  assign wc    = IW'(int'(addr) % N);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (sel) mem_b[wr][wc] <= wdata;
      else     mem_a[wr][wc] <= wdata;
    end
  end

  // Forward a same-cycle write so a start issued alongside it sees new data
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign row_a[k*DW +: DW] = (wr_ok && !sel && wr == ri && wc == IW'(k)) ? wdata : mem_a[ri][k];
    assign col_b[k*DW +: DW] = (wr_ok &&  sel && wr == IW'(k) && wc == cj) ? wdata : mem_b[k][cj];
  end
endmodule

// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: walks (i,j) row-major, feeds the MAC, emits results.
// Optional MATMUL_CTRL_CYCCNT_EN adds a 16-bit busy-cycle counter output cyc_cnt.
module matmul_ctrl import matmul_pkg::*; #(
  parameter int N  = MM_N,
  parameter int DW = MM_DW,
  parameter int RW = MM_RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_sel,
  input  logic [MM_AW-1:0] ld_addr,
  input  logic [DW-1:0]    ld_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N*DW-1:0]  a_row,
  output logic [N*DW-1:0]  b_col,
  output logic             mac_w_en,
  input  logic [RW-1:0]    mac_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [MM_IW-1:0] res_i,
  output logic [MM_IW-1:0] res_j,
`ifdef MATMUL_CTRL_CYCCNT_EN
  output logic [15:0]      cyc_cnt,
`endif
  output logic [RW-1:0]    res_data
);
  state_t           state_q, state_d;
  logic [MM_IW-1:0] i_q, j_q, i_d, j_d;
  logic             iss_ld, last;
  logic [N*DW-1:0]  rd_row, rd_col;

  assign last = (i_q == MM_IW'(N-1)) && (j_q == MM_IW'(N-1));

  matmul_opmem #(.N(N), .DW(DW), .IW(MM_IW), .AW(MM_AW)) u_opmem (
    .clk   (clk),
    .we    (ld_valid && state_q == S_IDLE),
    .sel   (ld_sel),
    .addr  (ld_addr),
    .wdata (ld_data),
    .ri    (i_d),
    .cj    (j_d),
    .row_a (rd_row),
    .col_b (rd_col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // iss_ld marks every transition into ISSUE; operands are read at the next index
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    iss_ld    = 1'b0;
    ld_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mac_w_en  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_ready = 1'b1;
        busy     = 1'b0;
        if (start) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          iss_ld  = 1'b1;
        end
      end
      S_ISSUE: begin
        mac_w_en = 1'b1;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_EMIT;
      S_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (last) state_d = S_DONE;
          else begin
            state_d = S_ISSUE;
            iss_ld  = 1'b1;
            if (j_q == MM_IW'(N-1)) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      a_row    <= '0;
      b_col    <= '0;
      res_data <= '0;
      res_i    <= '0;
      res_j    <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      if (iss_ld) begin
        a_row <= rd_row;
        b_col <= rd_col;
      end
      if (state_q == S_CAPTURE) begin
        res_data <= mac_r;
        res_i    <= i_q;
        res_j    <= j_q;
      end
    end
  end

`ifdef MATMUL_CTRL_CYCCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cyc_cnt <= '0;
    else if (state_q == S_IDLE && start) cyc_cnt <= '0;
    else if (state_q != S_IDLE)        cyc_cnt <= cyc_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: reference matrices + plain-arithmetic product.
module tb_matmul_ctrl;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int RW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ld_valid = 1'b0, ld_sel = 1'b0, start = 1'b0, res_ready = 1'b1;
  logic [6:0]      ld_addr = '0;
  logic [DW-1:0]   ld_data = '0;
  logic            ld_ready, busy, done, mac_w_en, res_valid;
  logic [N*DW-1:0] a_row, b_col;
  logic [RW-1:0]   mac_r = '0;
  logic [3:0]      res_i, res_j;
  logic [RW-1:0]   res_data;
`ifdef MATMUL_CTRL_CYCCNT_EN
  logic [15:0]     cyc_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic signed [DW-1:0] ma [N][N];
  logic signed [DW-1:0] mb [N][N];

  matmul_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .a_row     (a_row),
    .b_col     (b_col),
    .mac_w_en  (mac_w_en),
    .mac_r     (mac_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_i     (res_i),
    .res_j     (res_j),
`ifdef MATMUL_CTRL_CYCCNT_EN
    .cyc_cnt   (cyc_cnt),
`endif
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    int acc = 0;
    for (int k = 0; k < N; k++)
      acc += int'($signed(a[k*DW +: DW])) * int'($signed(b[k*DW +: DW]));
    return acc;
  endfunction

  // MAC that registers on its write enable
  always @(posedge clk) if (mac_w_en) mac_r <= dot(a_row, b_col);

  function automatic logic [RW-1:0] ref_c(input int i, input int j);
    int acc = 0;
    for (int k = 0; k < N; k++) acc += int'(ma[i][k]) * int'(mb[k][j]);
    return acc;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = 7'(addr); ld_data = d;
    total++;
    if (ld_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_idle got=%b want=1", ld_ready); end
    tick;
    ld_valid = 1'b0;
    if (addr < N*N) begin
      if (sel) mb[addr/N][addr%N] = d;
      else     ma[addr/N][addr%N] = d;
    end
  endtask

  // kind 0: A=I, B=r*10+c; 1: A=2, B=3; 2: random
  task automatic load_mats(input int kind);
    logic [DW-1:0] va, vb;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          0:       begin va = (r == c) ? 16'd1 : 16'd0; vb = 16'(r*10 + c); end
          1:       begin va = 16'd2; vb = 16'd3; end
          default: begin va = 16'($urandom); vb = 16'($urandom); end
        endcase
        wr(1'b0, r*N + c, va);
        wr(1'b1, r*N + c, vb);
      end
  endtask

  // mode 0: ready high; 1: 5-cycle stall at (0,0); 2: random ready.
  // poke drives a write and a start in mid-run; both must be ignored.
  task automatic run_mm(input int mode, input bit poke, output int dc);
    int nres, stall, ei, ej;
    bit want_iss, held;
    logic [3:0] hi, hj;
    logic [RW-1:0] hd, ev;
    logic [N*DW-1:0] ea, eb;
    start = 1'b1;
    tick;
    start = 1'b0; ld_valid = 1'b0;
    nres = 0; dc = -1; stall = (mode == 1) ? 5 : 0; want_iss = 1'b1; held = 1'b0;
    hi = '0; hj = '0; hd = '0;
    for (int c = 1; c < 3000 && dc < 0; c++) begin
      if (mode == 1 && res_valid && nres == 0 && stall > 0) begin res_ready = 1'b0; stall--; end
      else if (mode == 2) res_ready = ($urandom_range(0, 3) != 0);
      else res_ready = 1'b1;
      if (poke && c == 4) begin
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 7'd5; ld_data = 16'd7; start = 1'b1;
        total++;
        if (ld_ready !== 1'b0) begin bad++; $display("FAIL ld_ready_busy got=%b want=0", ld_ready); end
      end else begin
        ld_valid = 1'b0; start = 1'b0;
      end
      ei = nres / N; ej = nres % N;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy cyc=%0d got=%b want=1", c, busy); end
      total++;
      if (mac_w_en !== want_iss) begin
        bad++; $display("FAIL mac_w_en cyc=%0d got=%b want=%b", c, mac_w_en, want_iss);
      end
      if (mac_w_en) begin
        for (int k = 0; k < N; k++) begin ea[k*DW +: DW] = ma[ei][k]; eb[k*DW +: DW] = mb[k][ej]; end
        total++;
        if ({a_row, b_col} !== {ea, eb}) begin
          bad++; $display("FAIL lanes (%0d,%0d) got=%h/%h want=%h/%h", ei, ej, a_row, b_col, ea, eb);
        end
      end
      if (held) begin
        total++;
        if ({res_valid, res_i, res_j, res_data} !== {1'b1, hi, hj, hd}) begin
          bad++; $display("FAIL hold cyc=%0d got=%b %0d %0d %h want=1 %0d %0d %h",
                          c, res_valid, res_i, res_j, res_data, hi, hj, hd);
        end
      end
      held = 1'b0; want_iss = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          ev = ref_c(ei, ej);
          total++;
          if ({res_i, res_j, res_data} !== {4'(ei), 4'(ej), ev}) begin
            bad++; $display("FAIL result got=(%0d,%0d) %h want=(%0d,%0d) %h",
                            res_i, res_j, res_data, ei, ej, ev);
          end
          nres++;
          want_iss = (nres < N*N);
        end else begin
          held = 1'b1; hi = res_i; hj = res_j; hd = res_data;
        end
      end
      if (done) begin
        total++;
        if (nres != N*N) begin bad++; $display("FAIL done_count got=%0d want=100", nres); end
        dc = c;
      end
      tick;
    end
    res_ready = 1'b1; ld_valid = 1'b0; start = 1'b0;
    total++;
    if (dc < 0) begin bad++; $display("FAIL timeout got=no_done want=done"); end
    total++;
    if ({ld_ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL post_done got=%b want=100", {ld_ready, busy, done});
    end
`ifdef MATMUL_CTRL_CYCCNT_EN
    total++;
    if (int'(cyc_cnt) != dc) begin bad++; $display("FAIL cyc_cnt got=%0d want=%0d", cyc_cnt, dc); end
`endif
    tick; tick; tick;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_stays got=%b want=0", busy); end
`ifdef MATMUL_CTRL_CYCCNT_EN
    total++;
    if (int'(cyc_cnt) != dc) begin bad++; $display("FAIL cyc_cnt_frozen got=%0d want=%0d", cyc_cnt, dc); end
`endif
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, mac_w_en, res_valid, res_i, res_j, res_data} !== '0 || ld_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctl got=%b%b%b%b %0d %0d %h rdy=%b want=0 rdy=1",
                      busy, done, mac_w_en, res_valid, res_i, res_j, res_data, ld_ready);
    end
    total++;
    if ({a_row, b_col} !== '0) begin bad++; $display("FAIL reset_lanes got=%h want=0", {a_row, b_col}); end
`ifdef MATMUL_CTRL_CYCCNT_EN
    total++;
    if (cyc_cnt !== 16'd0) begin bad++; $display("FAIL reset_cyc got=%0d want=0", cyc_cnt); end
`endif
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_identity;
    int dc;
    load_mats(0);
    run_mm(0, 1'b0, dc);
    total++;
    if (dc != 301) begin bad++; $display("FAIL done_cycle got=%0d want=301", dc); end
  endtask

  task automatic test_const;
    int dc;
    load_mats(1);
    run_mm(0, 1'b0, dc);
    total++;
    if (ref_c(3, 7) != 32'd60) begin bad++; $display("FAIL const_model got=%0d want=60", ref_c(3, 7)); end
  endtask

  task automatic test_stall;
    int dc;
    run_mm(1, 1'b0, dc);
    total++;
    if (dc != 306) begin bad++; $display("FAIL stall_done_cycle got=%0d want=306", dc); end
  endtask

  task automatic test_busy_ignore;
    int dc;
    run_mm(0, 1'b1, dc);
    total++;
    if (dc != 301) begin bad++; $display("FAIL poke_done_cycle got=%0d want=301", dc); end
  endtask

  task automatic test_random;
    int dc;
    load_mats(2);
    wr(1'b0, 100, 16'h1234);
    wr(1'b1, 127, 16'h5678);
    run_mm(2, 1'b0, dc);
    total++;
    if (dc < 301) begin bad++; $display("FAIL random_done_cycle got=%0d want>=301", dc); end
  endtask

  task automatic test_same_cycle;
    int dc;
    logic [DW-1:0] v;
    v = 16'($urandom) | 16'h0100;
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 7'd0; ld_data = v;
    ma[0][0] = v;
    run_mm(0, 1'b0, dc);
  endtask

  task automatic test_reset_mid;
    int dc;
    start = 1'b1;
    tick;
    start = 1'b0; res_ready = 1'b0;
    tick; tick; tick; tick;
    total++;
    if (res_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_emit got=%b want=1", res_valid); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, mac_w_en, res_valid, res_i, res_j, res_data, a_row, b_col} !== '0 || ld_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset got=v%b d=%h rdy=%b want=v0 d=0 rdy=1", res_valid, res_data, ld_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; res_ready = 1'b1;
    tick;
    run_mm(0, 1'b0, dc);
    total++;
    if (dc != 301) begin bad++; $display("FAIL resume_done_cycle got=%0d want=301", dc); end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_const;
    test_stall;
    test_busy_ignore;
    test_random;
    test_same_cycle;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
